// File: rtl/ccm_stream_pipeline.sv
// Purpose: 3x3 signed fixed-point colour-correction matrix on a valid/ready RGB pixel stream.
// Latency: 3 edges from accept to m_valid (S1 multiply, S2 row sum, S3 round/clamp); 1 pixel/clk.
// Backpressure: credit check keeps pipeline + FIFO occupancy <= OUT_DEPTH, so stages never stall.
//
// Ports:
//   clk, rst_n            single rising-edge clock, asynchronous active-low reset
//   s_rgb/s_valid/s_ready input pixel stream (R in MSBs, B in LSBs)
//   comp_matrix           9 signed coefficients, k at [k*COEF_W +: COEF_W], row-major R,G,B rows
//   matrix_valid          level request to load comp_matrix once S1-S3 are empty
//   m_rgb/m_valid/m_ready output pixel stream (show-ahead FIFO head)
//   busy                  any pixel in S1-S3 or the output FIFO
// Optional: define CCM_CLIP_COUNT_EN to add clip_clr (in) and clip_count[15:0] (out), a
//   saturating count of channels clamped in S3.
module ccm_stream_pipeline #(
  parameter int CW        = 8,
  parameter int COEF_W    = 32,
  parameter int FRAC      = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3*CW-1:0]     s_rgb,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [9*COEF_W-1:0] comp_matrix,
  input  logic                matrix_valid,
  output logic [3*CW-1:0]     m_rgb,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy
`ifdef CCM_CLIP_COUNT_EN
  ,
  input  logic                clip_clr,
  output logic [15:0]         clip_count
`endif
);

  localparam int PW  = CW + COEF_W + 1;        // product width
  localparam int SW  = PW + 2;                 // row-sum width
  localparam int AW  = $clog2(OUT_DEPTH);      // FIFO pointer width
  localparam int OCW = AW + 2;                 // holds OUT_DEPTH + 3 in-flight
  localparam logic signed [SW-1:0] RND = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic [OCW-1:0] CREDITS = OCW'(OUT_DEPTH);

  // Coefficient register and loaded flag
  logic [9*COEF_W-1:0] coef_q, coef_d;
  logic                loaded_q, loaded_d;

  // Pipeline stages
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PW-1:0] prod_q [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [SW-1:0] sum_q [3];
  logic signed [SW-1:0] sum_d [3];
  logic signed [SW-1:0] sh_c [3];
  logic [3*CW-1:0]      rgb3_q, rgb3_d;

  // Output FIFO
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fcnt_q, fcnt_d;
  logic [3*CW-1:0] mem_q [OUT_DEPTH];

  logic           pop, accept;
  logic [1:0]     inflight;
  logic [OCW-1:0] occupancy;

  // Channel (zero-extended, so always non-negative) times signed coefficient.
  function automatic logic signed [PW-1:0] mul(input logic [CW-1:0] ch, input logic [COEF_W-1:0] k);
    logic signed [PW-1:0] a, b;
    a = signed'({{(PW-CW){1'b0}}, ch});
    b = signed'({{(PW-COEF_W){k[COEF_W-1]}}, k});
    return a * b;
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] p);
    return signed'({{(SW-PW){p[PW-1]}}, p});
  endfunction

  // Round half up, then arithmetic shift back to integer pixel units.
  function automatic logic signed [SW-1:0] round_shift(input logic signed [SW-1:0] s);
    return (s + RND) >>> FRAC;
  endfunction

  function automatic logic [CW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1])            return '0;
    else if (|v[SW-2:CW])   return '1;
    else                    return v[CW-1:0];
  endfunction

  // Flow control and status
  always_comb begin
    m_valid   = (fcnt_q != '0);
    m_rgb     = m_valid ? mem_q[rd_ptr_q] : '0;
    pop       = m_valid && m_ready;
    inflight  = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};
    // Credit: every pixel in S1-S3 already owns a FIFO slot; a pop this cycle frees one.
    occupancy = OCW'(inflight) + OCW'(fcnt_q) - OCW'(pop);
    s_ready   = loaded_q && !matrix_valid && (occupancy < CREDITS);
    accept    = s_valid && s_ready;
    busy      = (inflight != 2'd0) || m_valid;
  end

  // Coefficient load: only with S1-S3 empty so no pixel mixes two matrices.
  // s_ready is low while matrix_valid is high, so no pixel enters on the load edge.
  always_comb begin
    coef_d   = coef_q;
    loaded_d = loaded_q;
    if (matrix_valid && (inflight == 2'd0)) begin
      coef_d   = comp_matrix;
      loaded_d = 1'b1;
    end
  end

  // Datapath
  always_comb begin
    v1_d = accept;
    v2_d = v1_q;
    v3_d = v2_q;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        // input channel c: 0=R (MSBs), 1=G, 2=B (LSBs)
        prod_d[r*3+c] = mul(s_rgb[(2-c)*CW +: CW], coef_q[(r*3+c)*COEF_W +: COEF_W]);
      end
      sum_d[r] = sx(prod_q[r*3]) + sx(prod_q[r*3+1]) + sx(prod_q[r*3+2]);
    end
    rgb3_d = '0;
    for (int r = 0; r < 3; r++) begin
      sh_c[r] = round_shift(sum_q[r]);
      rgb3_d[(2-r)*CW +: CW] = sat(sh_c[r]);
    end
  end

  // FIFO pointers. Credits guarantee a slot for every S3 write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (v3_q) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    fcnt_d = fcnt_q + {{AW{1'b0}}, v3_q} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q   <= '0;
      loaded_q <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int i = 0; i < 3; i++) sum_q[i] <= '0;
      rgb3_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      coef_q   <= coef_d;
      loaded_q <= loaded_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int i = 0; i < 3; i++) sum_q[i] <= sum_d[i];
      rgb3_q   <= rgb3_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // FIFO storage needs no reset: m_rgb is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (v3_q) mem_q[wr_ptr_q] <= rgb3_q;
  end

`ifdef CCM_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic [1:0]  clip_n;
  logic [16:0] clip_sum;

  // A channel was clamped exactly when the saturated value differs from the shifted sum.
  always_comb begin
    clip_n = '0;
    for (int r = 0; r < 3; r++) begin
      if (v2_q && ({{(SW-CW){1'b0}}, rgb3_d[(2-r)*CW +: CW]} != sh_c[r])) clip_n = clip_n + 2'd1;
    end
    clip_sum = {1'b0, clip_cnt_q} + {15'd0, clip_n};
    if (clip_clr)          clip_cnt_d = '0;
    else if (clip_sum[16]) clip_cnt_d = 16'hFFFF;
    else                   clip_cnt_d = clip_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_cnt_q <= '0;
    else        clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule

// File: doc/ccm_stream_pipeline.md
# ccm_stream_pipeline

Parametrised, fully pipelined 3×3 colour-correction-matrix engine that succeeds the single-pixel `image_processor`. It accepts a streaming valid/ready RGB pixel interface and sustains one pixel per clock. Each pixel is multiplied by a signed fixed-point compensation matrix, then rounded and clamped. Results go through an output FIFO with full backpressure. It sits between the pixel source and the display/writeback path, and consumes `comp_matrix` from the chromatic-adaptation matrix generator.

## Interface
- `CW`, 8: bits per colour channel; pixel is 3*CW bits, R in MSBs, B in LSBs.
- `COEF_W`, 32: coefficient width, signed two's complement.
- `FRAC`, 16: fractional bits of each coefficient (Q(COEF_W-FRAC).FRAC).
- `OUT_DEPTH`, 4: output FIFO entries; power of 2, minimum 4.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_rgb` in 3*CW: input pixel.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: engine can accept a pixel.
- `comp_matrix` in 9*COEF_W: coefficient k at bits [k*COEF_W +: COEF_W].
  - k=0..2 are the R-output row, coefficients for R, G, B inputs.
  - k=3..5 are the G-output row; k=6..8 are the B-output row.
- `matrix_valid` in 1: level load request for `comp_matrix`.
- `m_rgb` out 3*CW: output pixel, FIFO head.
- `m_valid` out 1: output pixel valid.
- `m_ready` in 1: downstream accepts output.
- `busy` out 1: high if any pixel is in the pipeline or FIFO.

## Operation
- **Accept.** A pixel is accepted on a rising edge when `s_valid && s_ready`. A pixel is delivered when `m_valid && m_ready`.
- **Coefficient register.** The active coefficient register loads `comp_matrix` on every edge where `matrix_valid=1` and the in-flight count is 0 (stages S1–S3 empty). The first such load sets the internal `loaded` flag.
- **s_ready.** `s_ready = loaded && !matrix_valid && (inflight + fifo_count - (m_valid && m_ready)) < OUT_DEPTH`. This is combinational on `m_ready`, which gives credit-based no-overflow.
- **Pixels during a matrix change.** Pixels already in S1–S3 finish with the old matrix. No pixel is ever computed with a mixed matrix.
- **S1 stage.** Registers 9 products: channel (zero-extended to CW+1 bits, signed) × coefficient. Each product is CW+COEF_W+1 bits.
- **S2 stage.** Registers three row sums, each 2 bits wider than a product.
- **S3 stage.** Computes `sum + 2^(FRAC-1)`, then an arithmetic shift right by FRAC, then clamps:
  - results below 0 become 0;
  - results above 2^CW-1 become 2^CW-1.
  - The result is written to the FIFO.
- **FIFO.** Show-ahead: `m_rgb` is valid whenever `m_valid=1`. Order is preserved. The FIFO supports simultaneous read and write when full or empty.
- **busy.** `busy = (inflight != 0) || (fifo_count != 0)`.

## Timing
- **Reset values.** `s_ready=0`, `m_valid=0`, `m_rgb=0`, `busy=0`. Coefficients are 0, `loaded=0`, and all stage valids and FIFO pointers are 0.
- **Latency.** A pixel accepted at edge N has `m_valid` high after edge N+3, when `m_ready` was held high and the FIFO was empty.
- **Throughput.** One pixel per cycle with `m_ready` held high and `matrix_valid` low.
- **Stage advance.** Stages always advance; the credit check guarantees FIFO space.
- **Output stall.** With `m_ready=0`, at most OUT_DEPTH pixels are accepted. `s_ready` then stays low until a pop occurs.
- **Output hold.** While `m_valid && !m_ready`, `m_rgb` must stay stable.
- **Matrix load wait.** When `matrix_valid` rises with pixels in flight, `s_ready` drops in the same cycle. The load occurs on the first edge after S1–S3 drain, which is at most 3 edges later.
- **Reset mid-operation.** Asserting reset clears everything immediately, including any matrix that was loaded. `s_ready` stays 0 until a new `matrix_valid` load.

## Configuration
- Macro: `CCM_CLIP_COUNT_EN`.
- **Defined:**
  - Adds output `clip_count` [15:0]. It increments by the number of channels (0–3) clamped in S3 that cycle and saturates at 16'hFFFF.
  - Adds input `clip_clr`, which is synchronous and has priority over increment.
  - Both `clip_count` and `clip_clr` reset to 0.
- **Undefined:** these ports and the counter logic are absent; behaviour is otherwise identical.

## Test plan
- **Identity matrix:** diagonal 32'h00010000, other coefficients 0; stream 0x735244, 0x627A9D, 0x0885A1 back-to-back. Required: identical outputs in order, first `m_valid` 3 edges after the first accept, then one per cycle.
- **Warm matrix:** diagonal 32'h00011999 / 32'h00010CCC / 32'h0000E666.
  - Pixel 0xC29682 → 0xD59D75.
  - Pixel 0xF3F3F2 → 0xFFFFDA; `clip_count` increments by 1 (R only).
- **Negative coefficient:** identity with k=1 set to 32'hFFFF0000. Pixel 0x505BA6 → 0x005BA6 (R clamps to 0).
- **Backpressure:** hold `m_ready=0` and offer 10 pixels. Required: exactly 4 accepted and `s_ready` stays 0. Then release `m_ready`: all 10 pixels emerge in order with none lost or duplicated.
- **Matrix swap:** raise `matrix_valid` with 3 pixels in flight. Required: those 3 use the old matrix, the next pixel uses the new one, and `s_ready` is low during the wait.
- **Reset mid-stream:** assert `rst_n=0` with FIFO occupancy 2. Required: `m_valid`/`busy` drop immediately, and `s_ready` stays 0 until a matrix reload.
